// File: rtl/bisection_sched_if.sv
// Request, engine and response signal bundle for bisection_sched.
// Master is the requester/engine/consumer side; slave is the scheduler.
interface bisection_sched_if #(
  parameter int COEF_W  = 16,
  parameter int ALPHA_W = 20
);
  logic              req0_valid;
  logic              req1_valid;
  logic [COEF_W-1:0] req0_coef;
  logic [COEF_W-1:0] req1_coef;
  logic              req0_ready;
  logic              req1_ready;

  logic               eng_start;
  logic [COEF_W-1:0]  eng_coef;
  logic               eng_done;
  logic [ALPHA_W-1:0] eng_alpha;

  logic               rsp_valid;
  logic               rsp_id;
  logic [ALPHA_W-1:0] rsp_alpha;
  logic               rsp_err;
  logic               rsp_ready;

  logic busy;

  modport master (
    output req0_valid, req1_valid,
    output req0_coef, req1_coef,
    input  req0_ready, req1_ready,
    input  eng_start, eng_coef,
    output eng_done, eng_alpha,
    input  rsp_valid, rsp_id,
    input  rsp_alpha, rsp_err,
    output rsp_ready,
    input  busy
  );

  modport slave (
    input  req0_valid, req1_valid,
    input  req0_coef, req1_coef,
    output req0_ready, req1_ready,
    output eng_start, eng_coef,
    input  eng_done, eng_alpha,
    output rsp_valid, rsp_id,
    output rsp_alpha, rsp_err,
    input  rsp_ready,
    output busy
  );
endinterface

// File: rtl/bisection_sched.sv
// Two-requester round-robin front end for a bisection root engine.
// Optional RUN watchdog is enabled by defining BISECT_SCHED_TIMEOUT_EN.
module bisection_sched #(
  parameter int COEF_W         = 16,
  parameter int ALPHA_W        = 20,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic reset,
  bisection_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [COEF_W-1:0]  coef_q;
  logic [COEF_W-1:0]  coef_nx;
  logic               id_q;
  logic               id_nx;
  logic               prio_q;
  logic               prio_nx;
  logic [ALPHA_W-1:0] alpha_q;
  logic [ALPHA_W-1:0] alpha_nx;

  logic pick1;
  logic grant0;
  logic grant1;

  // prio_q names the requester that wins a tie
  assign pick1  = bus.req1_valid &
                  (~bus.req0_valid | prio_q);
  assign grant1 = (state == IDLE) & pick1;
  assign grant0 = (state == IDLE) &
                  bus.req0_valid & ~pick1;

`ifdef BISECT_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             expire;
  logic             err_q;
  logic             err_nx;

  assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state == START) begin
      cnt_q <= '0;
    end else if (state == RUN) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_nx;
    end
  end

  assign bus.rsp_err = err_q;
`else
  logic timeout_cfg_unused;
  assign timeout_cfg_unused = ^TIMEOUT_CYCLES;
  assign bus.rsp_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      coef_q  <= '0;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
      alpha_q <= '0;
    end else begin
      state   <= state_nx;
      coef_q  <= coef_nx;
      id_q    <= id_nx;
      prio_q  <= prio_nx;
      alpha_q <= alpha_nx;
    end
  end

  always_comb begin
    state_nx = state;
    coef_nx  = coef_q;
    id_nx    = id_q;
    prio_nx  = prio_q;
    alpha_nx = alpha_q;
`ifdef BISECT_SCHED_TIMEOUT_EN
    err_nx   = err_q;
`endif
    unique case (state)
      IDLE: begin
        if (grant0 | grant1) begin
          coef_nx  = grant1 ? bus.req1_coef
                            : bus.req0_coef;
          id_nx    = grant1;
          prio_nx  = ~grant1;
          state_nx = START;
        end
      end
      START: begin
        state_nx = RUN;
      end
      RUN: begin
        if (bus.eng_done) begin
          alpha_nx = bus.eng_alpha;
`ifdef BISECT_SCHED_TIMEOUT_EN
          err_nx   = 1'b0;
`endif
          state_nx = RESP;
        end
`ifdef BISECT_SCHED_TIMEOUT_EN
        else if (expire) begin
          alpha_nx = '0;
          err_nx   = 1'b1;
          state_nx = RESP;
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.eng_start  = (state == START);
  assign bus.eng_coef   = (state == IDLE) ? '0 : coef_q;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_alpha  = alpha_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_bisection_sched.sv
// Directed self-checking bench for bisection_sched.
// Watchdog cases follow BISECT_SCHED_TIMEOUT_EN.
module tb_bisection_sched;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   n_start;

  bisection_sched_if #(.COEF_W(16), .ALPHA_W(20)) bus ();

  bisection_sched #(
    .COEF_W(16),
    .ALPHA_W(20),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.eng_start === 1'b1) n_start = n_start + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "bench time limit reached");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts in IDLE with the winning request already offered.
  task automatic job(input logic id, input logic [19:0] a);
    logic [15:0] c;
    c = id ? 16'h2222 : 16'h1111;
    chk("job_ready0", 32'(bus.req0_ready), 32'(!id));
    chk("job_ready1", 32'(bus.req1_ready), 32'(id));
    step();
    chk("job_start", 32'(bus.eng_start), 1);
    chk("job_coef", 32'(bus.eng_coef), 32'(c));
    step();
    bus.eng_done  = 1'b1;
    bus.eng_alpha = a;
    step();
    bus.eng_done  = 1'b0;
    #1;
    chk("job_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("job_rsp_id", 32'(bus.rsp_id), 32'(id));
    chk("job_rsp_alpha", 32'(bus.rsp_alpha), 32'(a));
    chk("job_rsp_err", 32'(bus.rsp_err), 0);
    bus.rsp_ready = 1'b1;
    #1;
    chk("job_no_accept",
        32'(bus.req0_ready | bus.req1_ready), 0);
    step();
    bus.rsp_ready = 1'b0;
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    n_start    = 0;
    reset      = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_coef  = '0;
    bus.req1_coef  = '0;
    bus.eng_done   = 1'b0;
    bus.eng_alpha  = '0;
    bus.rsp_ready  = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_eng_start", 32'(bus.eng_start), 0);
    chk("rst_eng_coef", 32'(bus.eng_coef), 0);
    chk("rst_rsp_alpha", 32'(bus.rsp_alpha), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("rst_ready0", 32'(bus.req0_ready), 0);

    // single job, engine done 5 cycles after start
    n_start = 0;
    bus.req0_valid = 1'b1;
    bus.req0_coef  = 16'h1B2D;
    #1;
    chk("t1_ready0", 32'(bus.req0_ready), 1);
    chk("t1_ready1", 32'(bus.req1_ready), 0);
    step();
    bus.req0_valid = 1'b0;
    #1;
    chk("t1_start", 32'(bus.eng_start), 1);
    chk("t1_coef_start", 32'(bus.eng_coef), 32'h1B2D);
    chk("t1_busy", 32'(bus.busy), 1);
    chk("t1_ready_busy", 32'(bus.req0_ready), 0);
    step();
    chk("t1_start_low", 32'(bus.eng_start), 0);
    chk("t1_coef_run", 32'(bus.eng_coef), 32'h1B2D);
    repeat (4) step();
    chk("t1_no_rsp_run", 32'(bus.rsp_valid), 0);
    bus.eng_done  = 1'b1;
    bus.eng_alpha = 20'h0ABCD;
    step();
    bus.eng_done  = 1'b0;
    #1;
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("t1_rsp_id", 32'(bus.rsp_id), 0);
    chk("t1_rsp_alpha", 32'(bus.rsp_alpha), 32'h0ABCD);
    chk("t1_rsp_err", 32'(bus.rsp_err), 0);
    chk("t1_coef_resp", 32'(bus.eng_coef), 32'h1B2D);
    chk("t1_one_start", 32'(n_start), 1);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    #1;
    chk("t1_idle_valid", 32'(bus.rsp_valid), 0);
    chk("t1_idle_busy", 32'(bus.busy), 0);
    chk("t1_idle_coef", 32'(bus.eng_coef), 0);

    // contention from a fresh reset: grants 0,1,0,1
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_coef  = 16'h1111;
    bus.req1_valid = 1'b1;
    bus.req1_coef  = 16'h2222;
    #1;
    job(1'b0, 20'h00011);
    job(1'b1, 20'h00022);
    job(1'b0, 20'h00033);
    job(1'b1, 20'h00044);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;

    // backpressure on a req1 job, spurious done in RESP
    bus.req1_valid = 1'b1;
    #1;
    chk("bp_ready1", 32'(bus.req1_ready), 1);
    step();
    bus.req1_valid = 1'b0;
    step();
    bus.eng_done  = 1'b1;
    bus.eng_alpha = 20'h5A5A5;
    step();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.eng_done  = (i == 4);
      bus.eng_alpha = 20'hFFFFF;
      #1;
      chk("bp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_alpha", 32'(bus.rsp_alpha), 32'h5A5A5);
      chk("bp_id", 32'(bus.rsp_id), 1);
      chk("bp_no_ready",
          32'(bus.req0_ready | bus.req1_ready), 0);
      step();
    end
    bus.eng_done  = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_hs_no_ready",
        32'(bus.req0_ready | bus.req1_ready), 0);
    step();
    bus.rsp_ready = 1'b0;
    #1;
    chk("bp_after_valid", 32'(bus.rsp_valid), 0);
    chk("bp_after_ready0", 32'(bus.req0_ready), 1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;

    // spurious done in IDLE
    bus.eng_done  = 1'b1;
    bus.eng_alpha = 20'h12345;
    step();
    bus.eng_done  = 1'b0;
    #1;
    chk("sp_idle_busy", 32'(bus.busy), 0);
    chk("sp_idle_valid", 32'(bus.rsp_valid), 0);
    chk("sp_idle_alpha", 32'(bus.rsp_alpha), 32'h5A5A5);

    // reset while in RUN abandons the job
    bus.req0_valid = 1'b1;
    bus.req0_coef  = 16'h3333;
    step();
    bus.req0_valid = 1'b0;
    step();
    chk("rr_busy_run", 32'(bus.busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rr_busy_0", 32'(bus.busy), 0);
    chk("rr_alpha_0", 32'(bus.rsp_alpha), 0);
    bus.eng_done  = 1'b1;
    bus.eng_alpha = 20'h77777;
    step();
    bus.eng_done  = 1'b0;
    repeat (2) step();
    chk("rr_no_rsp", 32'(bus.rsp_valid), 0);
    chk("rr_still_idle", 32'(bus.busy), 0);
    chk("rr_coef_0", 32'(bus.eng_coef), 0);
    bus.req1_valid = 1'b1;
    bus.req1_coef  = 16'h2222;
    #1;
    job(1'b1, 20'h0BEEF);
    bus.req1_valid = 1'b0;
    #1;

`ifdef BISECT_SCHED_TIMEOUT_EN
    // engine never finishes: expiry after 8 RUN cycles
    bus.req0_valid = 1'b1;
    bus.req0_coef  = 16'h1111;
    step();
    bus.req0_valid = 1'b0;
    step();
    for (int i = 0; i < 7; i++) begin
      chk("to_wait_valid", 32'(bus.rsp_valid), 0);
      step();
    end
    chk("to_c8_valid", 32'(bus.rsp_valid), 0);
    chk("to_c8_busy", 32'(bus.busy), 1);
    step();
    chk("to_valid", 32'(bus.rsp_valid), 1);
    chk("to_err", 32'(bus.rsp_err), 1);
    chk("to_alpha", 32'(bus.rsp_alpha), 0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    // done on the expiry cycle wins
    bus.req0_valid = 1'b1;
    step();
    bus.req0_valid = 1'b0;
    step();
    repeat (7) step();
    bus.eng_done  = 1'b1;
    bus.eng_alpha = 20'h0ACED;
    step();
    bus.eng_done  = 1'b0;
    #1;
    chk("tw_valid", 32'(bus.rsp_valid), 1);
    chk("tw_err", 32'(bus.rsp_err), 0);
    chk("tw_alpha", 32'(bus.rsp_alpha), 32'h0ACED);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
`else
    // no watchdog: RUN outlasts any timeout setting
    bus.req0_valid = 1'b1;
    bus.req0_coef  = 16'h1111;
    step();
    bus.req0_valid = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      chk("nt_wait_valid", 32'(bus.rsp_valid), 0);
      chk("nt_wait_busy", 32'(bus.busy), 1);
      step();
    end
    bus.eng_done  = 1'b1;
    bus.eng_alpha = 20'h0ACED;
    step();
    bus.eng_done  = 1'b0;
    #1;
    chk("nt_valid", 32'(bus.rsp_valid), 1);
    chk("nt_err", 32'(bus.rsp_err), 0);
    chk("nt_alpha", 32'(bus.rsp_alpha), 32'h0ACED);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
`endif
    #1;
    chk("end_idle", 32'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/bisection_sched.md
BISECTION_SCHED -- requirements
Module: bisection_sched

Interface
REQ-001 SHALL have parameter COEF_W, default 16, meaning coefficient word width (eight 2-bit fields z01..z04, z11..z14 packed LSB-first).
REQ-002 SHALL have parameter ALPHA_W, default 20, meaning root-estimate width returned by the bisection engine.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the watchdog limit in clk cycles spent in RUN.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports req0_valid / req1_valid, input, 1 each, requester N offers a job.
REQ-007 SHALL have ports req0_coef / req1_coef, input, COEF_W each, the job coefficients.
REQ-008 SHALL have ports req0_ready / req1_ready, output, 1 each, job accepted this cycle.
REQ-009 SHALL have port eng_start, output, 1, one-cycle start pulse to the engine.
REQ-010 SHALL have port eng_coef, output, COEF_W, coefficients driven to the engine.
REQ-011 SHALL have ports eng_done, input, 1, and eng_alpha, input, ALPHA_W, engine completion pulse and result.
REQ-012 SHALL have ports rsp_valid, output, 1; rsp_id, output, 1; rsp_alpha, output, ALPHA_W; rsp_err, output, 1; rsp_ready, input, 1: shared response channel.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, START, RUN, RESP.
REQ-015 In IDLE with any reqN_valid, SHALL assert exactly one reqN_ready combinationally that cycle, latch its coef and id, and move to START.
REQ-016 Arbitration SHALL be round-robin: when both valid, grant the requester not granted last; last-grant pointer resets so req0 wins the first tie.
REQ-017 reqN_ready SHALL be low in all states other than IDLE.
REQ-018 START SHALL last exactly one cycle with eng_start=1, then go to RUN; eng_start SHALL be 0 in all other states.
REQ-019 eng_coef SHALL equal the latched coefficients from START until the RESP handshake; 0 in IDLE.
REQ-020 In RUN, eng_done=1 SHALL capture eng_alpha into rsp_alpha, set rsp_err=0, and move to RESP; eng_done outside RUN SHALL be ignored.
REQ-021 In RESP, rsp_valid SHALL be 1 and rsp_id/rsp_alpha/rsp_err stable until rsp_ready=1; on that cycle return to IDLE.
REQ-022 rsp_ready=1 while rsp_valid=0 SHALL have no effect.
REQ-023 Minimum job latency SHALL be: accept cycle t, eng_start at t+1, rsp_valid at t+3 when eng_done arrives at t+2.
REQ-024 A new job SHALL not be accepted in the cycle the response is consumed; earliest next accept is the following cycle.

Reset
REQ-025 On reset=1 at a clock edge, SHALL enter IDLE, clear latched coef, id, pointer, and watchdog; all outputs 0 next cycle.
REQ-026 Reset mid-job (START/RUN/RESP) SHALL abandon the job with no response emitted; a later eng_done SHALL be ignored.

Configuration
REQ-027 Macro BISECT_SCHED_TIMEOUT_EN SHALL enable the RUN watchdog.
REQ-028 With the macro defined: counter clears on entering RUN, increments each RUN cycle; on reaching TIMEOUT_CYCLES without eng_done, go to RESP with rsp_err=1, rsp_alpha=0; eng_done in the same cycle as expiry SHALL win (rsp_err=0).
REQ-029 Without the macro: no counter logic, rsp_err tied 0, RUN waits indefinitely for eng_done.

Verification
REQ-030 Single job: req0_valid, coef=16'h1B2D, engine done 5 cycles after start with alpha=20'h0ABCD -> eng_coef=16'h1B2D, one eng_start pulse, rsp_valid with rsp_id=0, rsp_alpha=20'h0ABCD, rsp_err=0.
REQ-031 Contention: req0 and req1 valid continuously for 4 jobs after reset -> grants 0,1,0,1 in order, responses carry matching rsp_id.
REQ-032 Backpressure: rsp_ready low 10 cycles after rsp_valid -> outputs stable 10 cycles, no new req*_ready until handshake+1.
REQ-033 Timeout (macro on, TIMEOUT_CYCLES=8): engine never done -> rsp_valid after 8 RUN cycles with rsp_err=1, rsp_alpha=0; with eng_done on cycle 8 -> rsp_err=0.
REQ-034 Reset in RUN: pulse reset 1 cycle, then eng_done -> no rsp_valid, busy=0, next req1 job proceeds normally.
REQ-035 Spurious eng_done in IDLE and RESP -> no state change, rsp_alpha unchanged.
